// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: receive side of a 4-digit multiplexed 7-segment scan.
// Decodes active-low segment patterns back to BCD and assembles frames.
//
// Parameters:
//   SEG_LAG       cycles seg trails sel (0..3)
//   STABLE_FRAMES identical good frames before stable (1..15)
//   TIMEOUT       cycles allowed per frame before scan_stall (8..65535)
// Ports:
//   clk, rst      scan clock, synchronous active-high reset
//   sel[3:0]      one-hot select: 0001 tens, 0010 hundreds,
//                 0100 thousands, 1000 units
//   seg[6:0]      {a,b,c,d,e,f,g}, active-low
//   value_bcd     last committed frame {thou,hund,tens,units}
//   frame_valid   pulse when value_bcd updates
//   changed       pulse with frame_valid when the value differs
//   stable        value repeated for STABLE_FRAMES good frames
//   scan_stall    pulse on frame timeout
//   err_cnt       saturating count of rejected frames
//   value_bin     binary value, only when SEG_SCAN_BIN_EN is defined
module seg_scan_decoder #(
    parameter int SEG_LAG       = 1,
    parameter int STABLE_FRAMES = 4,
    parameter int TIMEOUT       = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  sel,
    input  logic [6:0]  seg,
    output logic [15:0] value_bcd,
    output logic        frame_valid,
    output logic        changed,
    output logic        stable,
    output logic        scan_stall,
    output logic [7:0]  err_cnt
`ifdef SEG_SCAN_BIN_EN
    ,
    output logic [13:0] value_bin
`endif
);

    logic [3:0]  sel_d;
    logic [3:0]  digit;
    logic        digit_ok;
    logic        one_hot;
    logic [3:0]  mask, mask_n;
    logic        bad, bad_n;
    logic [15:0] tmo;
    logic [3:0]  scnt, scnt_n;
    logic [3:0]  s_th, s_hu, s_te, s_un;
    logic [3:0]  n_th, n_hu, n_te, n_un;
    logic [15:0] new_bcd;
    logic        done, open, expire;

    // Align sel with the segment bus, which the driver registers later.
    generate
        if (SEG_LAG == 0) begin : g_nolag
            assign sel_d = sel;
        end else begin : g_lag
            logic [3:0] dly [SEG_LAG];
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < SEG_LAG; i++) dly[i] <= 4'd0;
                end else begin
                    dly[0] <= sel;
                    for (int i = 1; i < SEG_LAG; i++) dly[i] <= dly[i-1];
                end
            end
            assign sel_d = dly[SEG_LAG-1];
        end
    endgenerate

    always_comb begin
        digit    = 4'd0;
        digit_ok = 1'b1;
        unique case (seg)
            7'b0000001: digit = 4'd0;
            7'b1001111: digit = 4'd1;
            7'b0010010: digit = 4'd2;
            7'b0000110: digit = 4'd3;
            7'b1001100: digit = 4'd4;
            7'b0100100: digit = 4'd5;
            7'b0100000: digit = 4'd6;
            7'b0001111: digit = 4'd7;
            7'b0000000: digit = 4'd8;
            7'b0000100: digit = 4'd9;
            default:    digit_ok = 1'b0;
        endcase
    end

    assign one_hot = (sel_d != 4'd0) && ((sel_d & (sel_d - 4'd1)) == 4'd0);

    always_comb begin
        n_th = s_th;
        n_hu = s_hu;
        n_te = s_te;
        n_un = s_un;
        if (one_hot && digit_ok) begin
            unique case (1'b1)
                sel_d[0]: n_te = digit;
                sel_d[1]: n_hu = digit;
                sel_d[2]: n_th = digit;
                sel_d[3]: n_un = digit;
                default:  ;
            endcase
        end
    end

    // Completion and timeout both see the current sample.
    assign mask_n  = mask | (one_hot ? sel_d : 4'd0);
    assign bad_n   = bad | (one_hot & ~digit_ok);
    assign done    = (mask_n == 4'hF);
    assign open    = (mask_n != 4'd0) && !done;
    assign expire  = open && (tmo == 16'(TIMEOUT - 1));
    assign new_bcd = {n_th, n_hu, n_te, n_un};

    always_comb begin
        scnt_n = 4'd1;
        if (new_bcd == value_bcd) begin
            scnt_n = (scnt >= 4'(STABLE_FRAMES)) ? scnt : scnt + 4'd1;
        end
    end

`ifdef SEG_SCAN_BIN_EN
    logic [13:0] bin_n;
    assign bin_n = {10'd0, n_th} * 14'd1000 + {10'd0, n_hu} * 14'd100
                 + {10'd0, n_te} * 14'd10 + {10'd0, n_un};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            value_bcd   <= 16'd0;
            frame_valid <= 1'b0;
            changed     <= 1'b0;
            stable      <= 1'b0;
            scan_stall  <= 1'b0;
            err_cnt     <= 8'd0;
            mask        <= 4'd0;
            bad         <= 1'b0;
            tmo         <= 16'd0;
            scnt        <= 4'd0;
            s_th        <= 4'd0;
            s_hu        <= 4'd0;
            s_te        <= 4'd0;
            s_un        <= 4'd0;
`ifdef SEG_SCAN_BIN_EN
            value_bin   <= 14'd0;
`endif
        end else begin
            frame_valid <= 1'b0;
            changed     <= 1'b0;
            scan_stall  <= 1'b0;
            s_th        <= n_th;
            s_hu        <= n_hu;
            s_te        <= n_te;
            s_un        <= n_un;
            if (done) begin
                mask <= 4'd0;
                bad  <= 1'b0;
                tmo  <= 16'd0;
                if (!bad_n) begin
                    value_bcd   <= new_bcd;
                    frame_valid <= 1'b1;
                    changed     <= (new_bcd != value_bcd);
                    scnt        <= scnt_n;
                    stable      <= (scnt_n >= 4'(STABLE_FRAMES));
`ifdef SEG_SCAN_BIN_EN
                    value_bin   <= bin_n;
`endif
                end else begin
                    err_cnt <= (err_cnt != 8'hFF) ? err_cnt + 8'd1 : err_cnt;
                    scnt    <= 4'd0;
                    stable  <= 1'b0;
                end
            end else if (expire) begin
                mask       <= 4'd0;
                bad        <= 1'b0;
                tmo        <= 16'd0;
                scan_stall <= 1'b1;
                scnt       <= 4'd0;
                stable     <= 1'b0;
            end else begin
                mask <= mask_n;
                bad  <= bad_n;
                tmo  <= open ? tmo + 16'd1 : tmo;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder: directed scenarios plus randomized scan traffic
// checked against an integer-level frame model.
module tb_seg_scan_decoder;

    localparam int LAG = 1;
    localparam int SF  = 4;
    localparam int TMO = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  sel;
    logic [6:0]  seg;
    logic [15:0] value_bcd;
    logic        frame_valid, changed, stable, scan_stall;
    logic [7:0]  err_cnt;
`ifdef SEG_SCAN_BIN_EN
    logic [13:0] value_bin;
`endif

    seg_scan_decoder #(
        .SEG_LAG(LAG), .STABLE_FRAMES(SF), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst), .sel(sel), .seg(seg),
        .value_bcd(value_bcd), .frame_valid(frame_valid),
        .changed(changed), .stable(stable),
        .scan_stall(scan_stall), .err_cnt(err_cnt)
`ifdef SEG_SCAN_BIN_EN
        , .value_bin(value_bin)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [6:0] pat [10];
    int         placeof [4];
    logic [3:0] rot [4];

    // model state: digits indexed by decimal place (0 = units)
    logic [3:0] m_hist [$];
    int m_dig [4];
    bit m_seen [4];
    bit m_bad;
    int m_open, m_val, m_rep, m_err;
    bit e_fv, e_ch, e_st, e_stall;

    // observations from run_frames
    int nfv;
    bit o_ch [16];
    bit o_st [16];
    logic [15:0] o_vb [16];
    int o_at [16];
    int o_bin [16];

    function automatic int digit_of(input int v, input int p);
        int q;
        q = v;
        for (int i = 0; i < p; i++) q = q / 10;
        return q % 10;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(digit_of(v, 3)), 4'(digit_of(v, 2)),
                4'(digit_of(v, 1)), 4'(digit_of(v, 0))};
    endfunction

    function automatic int place_of_sel(input logic [3:0] s);
        int p;
        p = 0;
        for (int k = 0; k < 4; k++) if (s[k]) p = placeof[k];
        return p;
    endfunction

    task automatic model(input logic r, input logic [3:0] s,
                         input logic [6:0] g);
        logic [3:0] sd;
        int p, d, nv;
        bit all, any;
        e_fv = 0; e_ch = 0; e_stall = 0;
        if (r) begin
            m_hist.delete();
            for (int i = 0; i < LAG; i++) m_hist.push_back(4'd0);
            for (int i = 0; i < 4; i++) m_seen[i] = 0;
            m_bad = 0; m_open = 0; m_val = 0; m_rep = 0; m_err = 0;
        end else begin
            if (LAG == 0) sd = s;
            else begin
                sd = m_hist.pop_front();
                m_hist.push_back(s);
            end
            if ($countones(sd) == 1) begin
                p = place_of_sel(sd);
                d = -1;
                for (int i = 0; i < 10; i++) if (pat[i] == g) d = i;
                if (d < 0) m_bad = 1;
                else m_dig[p] = d;
                m_seen[p] = 1;
            end
            all = 1; any = 0;
            for (int i = 0; i < 4; i++) begin
                all = all & m_seen[i];
                any = any | m_seen[i];
            end
            if (all) begin
                nv = m_dig[3] * 1000 + m_dig[2] * 100 + m_dig[1] * 10 + m_dig[0];
                if (!m_bad) begin
                    e_fv = 1;
                    e_ch = (nv != m_val);
                    m_rep = e_ch ? 1 : ((m_rep < SF) ? m_rep + 1 : SF);
                    m_val = nv;
                end else begin
                    m_err = (m_err < 255) ? m_err + 1 : 255;
                    m_rep = 0;
                end
                for (int i = 0; i < 4; i++) m_seen[i] = 0;
                m_bad = 0; m_open = 0;
            end else if (any) begin
                if (m_open == TMO - 1) begin
                    e_stall = 1;
                    for (int i = 0; i < 4; i++) m_seen[i] = 0;
                    m_bad = 0; m_open = 0; m_rep = 0;
                end else m_open++;
            end
        end
        e_st = (m_rep >= SF);
    endtask

    task automatic step(input logic r, input logic [3:0] s,
                        input logic [6:0] g);
        rst = r; sel = s; seg = g;
        @(posedge clk);
        model(r, s, g);
        #1;
    endtask

    // Rotating scan of value v for n frames; badk corrupts one select bit.
    task automatic run_frames(input int v, input int n, input int badk);
        logic [3:0] s;
        logic [6:0] g;
        int k;
        nfv = 0;
        for (int i = 0; i <= 4 * n; i++) begin
            s = (i == 4 * n) ? 4'd0 : rot[i % 4];
            if (i == 0) g = 7'h7F;
            else begin
                k = (i - 1) % 4;
                g = (k == badk) ? 7'h7F : pat[digit_of(v, placeof[k])];
            end
            step(1'b0, s, g);
            if (frame_valid) begin
                if (nfv < 16) begin
                    o_ch[nfv] = changed;
                    o_st[nfv] = stable;
                    o_vb[nfv] = value_bcd;
                    o_at[nfv] = i;
`ifdef SEG_SCAN_BIN_EN
                    o_bin[nfv] = int'(value_bin);
`else
                    o_bin[nfv] = 0;
`endif
                end
                nfv++;
            end
        end
    endtask

    task automatic test_reset();
        step(1'b1, 4'($urandom), 7'($urandom));
        step(1'b1, 4'($urandom), 7'($urandom));
        n_cmp++;
        if (value_bcd !== 16'h0) begin
            n_bad++; $display("FAIL reset_value got %h want 0000", value_bcd);
        end
        n_cmp++;
        if ({frame_valid, changed, stable, scan_stall} !== 4'b0) begin
            n_bad++;
            $display("FAIL reset_flags got %b want 0000",
                     {frame_valid, changed, stable, scan_stall});
        end
        n_cmp++;
        if (err_cnt !== 8'd0) begin
            n_bad++; $display("FAIL reset_err got %0d want 0", err_cnt);
        end
`ifdef SEG_SCAN_BIN_EN
        n_cmp++;
        if (value_bin !== 14'd0) begin
            n_bad++; $display("FAIL reset_bin got %0d want 0", value_bin);
        end
`endif
        step(1'b0, 4'd0, 7'h7F);
    endtask

    task automatic test_count_1234();
        run_frames(1234, 4, -1);
        n_cmp++;
        if (nfv !== 4) begin
            n_bad++; $display("FAIL c1234_frames got %0d want 4", nfv);
        end else begin
            n_cmp++;
            if (o_at[0] !== 4) begin
                n_bad++; $display("FAIL c1234_latency got %0d want 4", o_at[0]);
            end
            n_cmp++;
            if (o_vb[0] !== 16'h1234) begin
                n_bad++; $display("FAIL c1234_value got %h want 1234", o_vb[0]);
            end
            n_cmp++;
            if ({o_ch[0], o_ch[1]} !== 2'b10) begin
                n_bad++;
                $display("FAIL c1234_changed got %b want 10", {o_ch[0], o_ch[1]});
            end
            n_cmp++;
            if ({o_st[2], o_st[3]} !== 2'b01) begin
                n_bad++;
                $display("FAIL c1234_stable got %b want 01", {o_st[2], o_st[3]});
            end
`ifdef SEG_SCAN_BIN_EN
            n_cmp++;
            if (o_bin[0] !== 1234) begin
                n_bad++; $display("FAIL c1234_bin got %0d want 1234", o_bin[0]);
            end
`endif
        end
    endtask

    task automatic test_increment();
        run_frames(9, 4, -1);
        n_cmp++;
        if (nfv !== 4 || o_ch[0] !== 1'b1 || o_st[3] !== 1'b1) begin
            n_bad++;
            $display("FAIL inc_0009 got n=%0d ch=%b st=%b want 4 1 1",
                     nfv, o_ch[0], o_st[3]);
        end
        run_frames(10, 4, -1);
        n_cmp++;
        if (nfv !== 4 || o_vb[0] !== 16'h0010 || o_ch[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL inc_0010 got n=%0d v=%h ch=%b want 4 0010 1",
                     nfv, o_vb[0], o_ch[0]);
        end
        n_cmp++;
        if ({o_st[0], o_st[1], o_st[2], o_st[3]} !== 4'b0001) begin
            n_bad++;
            $display("FAIL inc_stable got %b want 0001",
                     {o_st[0], o_st[1], o_st[2], o_st[3]});
        end
    endtask

    task automatic test_bad_pattern();
        run_frames(5678, 1, 1);
        n_cmp++;
        if (nfv !== 0 || value_bcd !== 16'h0010 || stable !== 1'b0) begin
            n_bad++;
            $display("FAIL bad_hold got n=%0d v=%h st=%b want 0 0010 0",
                     nfv, value_bcd, stable);
        end
        n_cmp++;
        if (err_cnt !== 8'd1) begin
            n_bad++; $display("FAIL bad_err1 got %0d want 1", err_cnt);
        end
        run_frames(5678, 299, 1);
        n_cmp++;
        if (err_cnt !== 8'd255) begin
            n_bad++; $display("FAIL bad_err_sat got %0d want 255", err_cnt);
        end
    endtask

    task automatic test_stall();
        int nst, t0, t1, fvs;
        nst = 0; t0 = -1; t1 = -1; fvs = 0;
        for (int i = 0; i < 200; i++) begin
            step(1'b0, 4'b0001, pat[0]);
            if (scan_stall) begin
                if (nst == 0) t0 = i;
                if (nst == 1) t1 = i;
                nst++;
            end
            if (frame_valid) fvs++;
        end
        n_cmp++;
        if (nst !== 3 || t0 !== 64 || t1 !== 128) begin
            n_bad++;
            $display("FAIL stall_period got n=%0d t0=%0d t1=%0d want 3 64 128",
                     nst, t0, t1);
        end
        n_cmp++;
        if (fvs !== 0 || err_cnt !== 8'd255) begin
            n_bad++;
            $display("FAIL stall_noframe got fv=%0d err=%0d want 0 255",
                     fvs, err_cnt);
        end
        for (int i = 0; i < 70; i++) step(1'b0, 4'd0, 7'h7F);
    endtask

    task automatic test_reset_mid();
        step(1'b0, 4'b0001, 7'h7F);
        step(1'b0, 4'b0010, pat[1]);
        step(1'b0, 4'b0100, pat[1]);
        step(1'b1, 4'b1000, pat[1]);
        n_cmp++;
        if (value_bcd !== 16'h0 || err_cnt !== 8'd0 ||
            {frame_valid, changed, stable, scan_stall} !== 4'b0) begin
            n_bad++;
            $display("FAIL midrst_outputs got v=%h e=%0d f=%b want 0 0 0000",
                     value_bcd, err_cnt,
                     {frame_valid, changed, stable, scan_stall});
        end
        step(1'b0, 4'd0, 7'h7F);
        run_frames(9999, 1, -1);
        n_cmp++;
        if (nfv !== 1 || o_vb[0] !== 16'h9999 || o_ch[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL midrst_9999 got n=%0d v=%h ch=%b want 1 9999 1",
                     nfv, o_vb[0], o_ch[0]);
        end
    endtask

    task automatic test_invalid_sel();
        logic [3:0] seq [10];
        logic [3:0] prev;
        logic [6:0] g;
        int at;
        seq = '{4'b0001, 4'b0011, 4'b0010, 4'b0000, 4'b0000,
                4'b0100, 4'b0011, 4'b1000, 4'b0000, 4'b0000};
        prev = 4'd0; nfv = 0; at = -1;
        for (int i = 0; i < 10; i++) begin
            if ($countones(prev) == 1)
                g = pat[digit_of(507, place_of_sel(prev))];
            else g = 7'($urandom);
            step(1'b0, seq[i], g);
            if (frame_valid) begin
                nfv++; at = i; o_vb[0] = value_bcd; o_ch[0] = changed;
            end
            prev = seq[i];
        end
        n_cmp++;
        if (nfv !== 1 || at !== 8) begin
            n_bad++;
            $display("FAIL badsel_frame got n=%0d at=%0d want 1 8", nfv, at);
        end
        n_cmp++;
        if (value_bcd !== 16'h0507 || o_ch[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL badsel_value got %h ch=%b want 0507 1",
                     value_bcd, o_ch[0]);
        end
    endtask

    task automatic test_random();
        logic [3:0] s, prev;
        logic [6:0] g;
        logic r;
        int x, rv;
        prev = 4'd0;
        rv = 4321;
        for (int i = 0; i < 2000; i++) begin
            r = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 39) == 0) rv = $urandom_range(0, 9999);
            x = $urandom_range(0, 9);
            if (x <= 6) s = rot[$urandom_range(0, 3)];
            else if (x == 7) s = 4'd0;
            else s = 4'($urandom);
            if ($countones(prev) == 1 && $urandom_range(0, 19) != 0)
                g = pat[digit_of(rv, place_of_sel(prev))];
            else g = 7'($urandom);
            step(r, s, g);
            prev = r ? 4'd0 : s;
            n_cmp++;
            if (value_bcd !== to_bcd(m_val)) begin
                n_bad++;
                $display("FAIL rnd_value cyc %0d got %h want %h",
                         i, value_bcd, to_bcd(m_val));
            end
            n_cmp++;
            if ({frame_valid, changed, stable, scan_stall} !==
                {e_fv, e_ch, e_st, e_stall}) begin
                n_bad++;
                $display("FAIL rnd_flags cyc %0d got %b want %b", i,
                         {frame_valid, changed, stable, scan_stall},
                         {e_fv, e_ch, e_st, e_stall});
            end
            n_cmp++;
            if (int'(err_cnt) !== m_err) begin
                n_bad++;
                $display("FAIL rnd_err cyc %0d got %0d want %0d",
                         i, err_cnt, m_err);
            end
`ifdef SEG_SCAN_BIN_EN
            n_cmp++;
            if (int'(value_bin) !== m_val) begin
                n_bad++;
                $display("FAIL rnd_bin cyc %0d got %0d want %0d",
                         i, value_bin, m_val);
            end
`endif
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        pat = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                7'b0000000, 7'b0000100};
        placeof = '{1, 2, 3, 0};
        rot = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        rst = 1'b1;
        sel = 4'd0;
        seg = 7'h7F;
        test_reset();
        test_count_1234();
        test_increment();
        test_bad_pattern();
        test_stall();
        test_reset_mid();
        test_invalid_sel();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
- Receive-side counterpart of the 4-digit multiplexed 7-segment driver.
- Samples the one-hot digit select and the shared segment bus, decodes each active-low segment pattern back to BCD, and assembles complete 4-digit frames.
- Reports committed value, frame strobe, stability, scan stall and pattern errors.
- Used for on-chip loopback self-check of the display path and for bench scoreboarding.

Parameters:
- SEG_LAG, 1, cycles by which seg trails sel (the driver registers segments one clock after select); legal 0..3
- STABLE_FRAMES, 4, consecutive identical committed frames before stable asserts; legal 1..15
- TIMEOUT, 64, cycles allowed to complete a frame before scan_stall; legal 8..65535

Ports:
- clk  in  1  system clock (display scan clock domain)
- rst  in  1  synchronous reset, active-high
- sel  in  4  one-hot digit select: 0001=tens, 0010=hundreds, 0100=thousands, 1000=units
- seg  in  7  segments {a,b,c,d,e,f,g}, active-low
- value_bcd  out  16  last committed frame {thousands,hundreds,tens,units}
- frame_valid  out  1  one-cycle pulse when value_bcd is updated
- changed  out  1  one-cycle pulse with frame_valid when the new value differs from the previous committed value
- stable  out  1  level; value_bcd repeated for STABLE_FRAMES consecutive good frames
- scan_stall  out  1  one-cycle pulse on frame timeout
- err_cnt  out  8  saturating count of rejected frames

Behaviour:
- Reset (rst=1 at a clk edge): value_bcd=0, frame_valid=0, changed=0, stable=0, scan_stall=0, err_cnt=0. Capture mask, bad flag, timeout counter, stable counter and sel delay line are cleared (delay line cleared to 0000). rst dominates all other events.
- Alignment: sel is delayed SEG_LAG cycles (sel_d); seg at cycle N pairs with sel_d at cycle N. With SEG_LAG=0 no delay.
- Decode table (seg -> digit):
  - 0000001=0, 1001111=1, 0010010=2, 0000110=3, 1001100=4
  - 0100100=5, 0100000=6, 0001111=7, 0000000=8, 0000100=9
  - Any other pattern is invalid.
- Capture:
  - sel_d one-hot: store the decoded digit in the mapped slot and set that mask bit. A re-hit of the same slot overwrites it.
  - sel_d one-hot with an invalid pattern: set the bad flag and set the mask bit.
  - sel_d zero or multi-hot: sample ignored, no state change except the timeout counter.
- Frame completion: on the cycle the mask becomes 1111 (evaluated including the current capture), the next cycle:
  - bad=0: value_bcd is loaded from the slots and frame_valid=1. changed=1 if the new value differs from the old. The stable counter increments (saturating at STABLE_FRAMES) if the value is unchanged, otherwise it loads 1.
  - bad=1: value_bcd is held, no frame_valid, err_cnt+1 (saturates at 255), stable counter cleared.
  - Either way, mask, bad and the timeout counter are cleared.
- stable = (stable counter >= STABLE_FRAMES); it is a registered output, updated the same cycle as frame_valid.
- Timeout:
  - Counter runs while the mask is non-zero and incomplete.
  - On reaching TIMEOUT-1: scan_stall pulses, mask/bad clear, stable counter clears, err_cnt is unchanged.
  - A driver held in reset (select stuck at 0001) therefore yields periodic scan_stall and no frames.
- Latency: the last digit's seg sample leads to frame_valid after exactly 1 clk.

Optional Feature:
- Macro SEG_SCAN_BIN_EN.
- Defined: extra output value_bin [13:0] = thousands*1000+hundreds*100+tens*10+units. It is computed from the slot registers and registered on the same edge as value_bcd, so frame_valid qualifies both with zero extra latency. Reset value is 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Scan a 0001,0010,0100,1000 rotation (SEG_LAG=1) showing 1234 (tens=3, hunds=2, thous=1, units=4 patterns) -> frame_valid 1 cycle after the units sample, value_bcd=16'h1234, changed=1; 4 identical frames -> stable=1 on the 4th frame_valid; value_bin=1234 if SEG_SCAN_BIN_EN.
- Increment the displayed value 0009->0010 between frames -> changed pulses, stable drops to 0 and reasserts after 4 more frames of 0010.
- Inject seg=1111111 on the hundreds slot -> no frame_valid for that frame, value_bcd held, err_cnt 0->1; 300 such frames -> err_cnt=255.
- Hold sel=0001 with the "0" pattern (driver in reset) -> no frame_valid; scan_stall pulses every 64 cycles.
- Assert rst mid-frame after 2 digits captured -> all outputs 0 next cycle; the following complete scan of 9999 commits 16'h9999 with changed=1.
- Drive sel=0011 and sel=0000 for several cycles interleaved with a valid scan of 0507 -> invalid selects ignored, value_bcd=16'h0507.
